// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// IDLE arbitrates (one cycle, no beat accepted); LOCKED streams the granted packet until its last beat.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [CNT_W-1:0]              pkt_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;

    logic [NUM_REQ-1:0]   rot_valid;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic                 g_valid;
    logic                 g_last;
    logic                 xfer;
    logic [DATA_WIDTH-1:0] g_data;

    // Rotate requests so bit 0 is rr_ptr, find the lowest set bit, then rotate the index back.
    always_comb begin
        rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        win_found = |rot_valid;
        win_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                win_off = IDX_W'(i);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            win_sum = win_sum - (IDX_W + 1)'(NUM_REQ);
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_q == IDX_W'(i)) begin
                g_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        g_valid = |(req_valid & grant_q);
        g_last  = |(req_last & grant_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        g_d           = g_q;
        rr_ptr_d      = rr_ptr_q;
        pkt_count_d   = pkt_count_q;
        req_ready     = '0;
        fifo_write_en = 1'b0;
        fifo_data_in  = '0;
        xfer          = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    g_d     = win_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                req_ready     = fifo_full ? '0 : grant_q;
                xfer          = g_valid && !fifo_full;
                fifo_write_en = xfer;
                if (xfer) begin
                    fifo_data_in = g_data;
                end
                if (xfer && g_last) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
                    pkt_count_d = pkt_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester beat sources feed the DUT and the
// expected FIFO write order is queued up front, then checked beat by beat as writes occur.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [7:0]  fifo_data_in;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] pkt_count;

    logic [8:0]  src [4][$];
    logic [7:0]  exp_q [$];
    logic [3:0]  fire;
    logic [3:0]  hold_nxt;
    logic        full_nxt;
    int          total = 0;
    int          bad = 0;

    fifo_wr_arbiter #(
        .DATA_WIDTH(8),
        .NUM_REQ   (4),
        .IDX_W     (2),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_data_in (fifo_data_in),
        .grant        (grant),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            if (src[i].size() > 0 && !hold_nxt[i]) begin
                h = src[i][0];
                req_valid[i] = 1'b1;
                req_data[i*8 +: 8] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        fifo_full = full_nxt;
    endtask

    task automatic monitor();
        logic [7:0] e;
        fire = req_valid & req_ready;
        total++;
        if ((req_ready & ~grant) !== 4'b0000) begin
            bad++;
            $display("FAIL ready_outside_grant: ready=%b grant=%b", req_ready, grant);
        end
        if (fifo_full === 1'b1) begin
            total++;
            if (fifo_write_en !== 1'b0) begin
                bad++;
                $display("FAIL write_while_full: write_en=%b required 0", fifo_write_en);
            end
        end
        if (fifo_write_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: data=%h, no beat expected", fifo_data_in);
            end else begin
                e = exp_q.pop_front();
                if (fifo_data_in !== e) begin
                    bad++;
                    $display("FAIL fifo_data: got=%h exp=%h", fifo_data_in, e);
                end
            end
        end else begin
            total++;
            if (fifo_data_in !== 8'h00) begin
                bad++;
                $display("FAIL idle_data: got=%h exp=00", fifo_data_in);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
        end
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src[i].delete();
        exp_q.delete();
        fire = '0;
        hold_nxt = '0;
        full_nxt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: left=%0d busy=%b required 0/0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        src[0].push_back({1'b1, 8'h5A});
        src[2].push_back({1'b0, 8'hA5});
        drive();
        repeat (3) @(posedge clk);
        #2;
        total += 6;
        if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got=%b exp=0000", grant); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b exp=0", busy); end
        if (pkt_count !== 16'd0) begin bad++; $display("FAIL rst_pkt: got=%0d exp=0", pkt_count); end
        if (fifo_write_en !== 1'b0) begin bad++; $display("FAIL rst_we: got=%b exp=0", fifo_write_en); end
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got=%b exp=0000", req_ready); end
        if (fifo_data_in !== 8'h00) begin bad++; $display("FAIL rst_data: got=%h exp=00", fifo_data_in); end
        do_reset();
    endtask

    task automatic test_single();
        src[0].push_back({1'b0, 8'h11});
        src[0].push_back({1'b0, 8'h22});
        src[0].push_back({1'b1, 8'h33});
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        tick();
        total++;
        if (grant !== 4'b0000 || fifo_write_en !== 1'b0) begin
            bad++;
            $display("FAIL single_c0: grant=%b we=%b exp 0000/0", grant, fifo_write_en);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++;
            if (fifo_write_en !== (c <= 3)) begin
                bad++;
                $display("FAIL single_we_c%0d: got=%b exp=%b", c, fifo_write_en, (c <= 3));
            end
            total++;
            if (grant !== ((c <= 3) ? 4'b0001 : 4'b0000) || busy !== (c <= 3)) begin
                bad++;
                $display("FAIL single_grant_c%0d: grant=%b busy=%b", c, grant, busy);
            end
        end
        total++;
        if (pkt_count !== 16'd1) begin bad++; $display("FAIL single_pkt: got=%0d exp=1", pkt_count); end
        drain("single");
    endtask

    task automatic test_contention();
        logic [3:0] eg;
        do_reset();
        src[0].push_back({1'b0, 8'hA0});
        src[0].push_back({1'b1, 8'hA1});
        src[2].push_back({1'b0, 8'hC0});
        src[2].push_back({1'b1, 8'hC1});
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        tick();
        for (int c = 1; c <= 6; c++) begin
            tick();
            eg = (c == 1 || c == 2) ? 4'b0001 : (c == 4 || c == 5) ? 4'b0100 : 4'b0000;
            total++;
            if (grant !== eg) begin
                bad++;
                $display("FAIL contention_grant_c%0d: got=%b exp=%b", c, grant, eg);
            end
        end
        // With rr_ptr at 3, requester 3 must beat requester 0.
        src[0].push_back({1'b1, 8'hB0});
        src[3].push_back({1'b1, 8'hD0});
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hB0);
        tick();
        tick();
        total++;
        if (grant !== 4'b1000) begin bad++; $display("FAIL contention_rrptr: got=%b exp=1000", grant); end
        drain("contention");
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) src[i].push_back({1'b1, 8'(i * 16 + k)});
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 16 + k));
        tick();
        for (int c = 1; c <= 16; c++) begin
            tick();
            eg = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
            total++;
            if (grant !== eg) begin
                bad++;
                $display("FAIL fair_grant_c%0d: got=%b exp=%b", c, grant, eg);
            end
        end
        total++;
        if (pkt_count !== 16'd8) begin bad++; $display("FAIL fair_pkt16: got=%0d exp=8", pkt_count); end
        drain("fairness");
        total++;
        if (pkt_count !== 16'd12) begin bad++; $display("FAIL fair_pkt_end: got=%0d exp=12", pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            src[1].push_back({(b == 3), 8'(8'h90 + b)});
            exp_q.push_back(8'(8'h90 + b));
        end
        tick();
        tick();
        total++;
        if (grant !== 4'b0010 || fifo_write_en !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: grant=%b we=%b exp 0010/1", grant, fifo_write_en);
        end
        full_nxt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (req_ready[1] !== 1'b0 || fifo_write_en !== 1'b0 || grant !== 4'b0010) begin
                bad++;
                $display("FAIL bp_full_%0d: ready1=%b we=%b grant=%b exp 0/0/0010",
                         c, req_ready[1], fifo_write_en, grant);
            end
        end
        full_nxt = 1'b0;
        drain("backpressure");
        total++;
        if (pkt_count !== 16'd1) begin bad++; $display("FAIL bp_pkt: got=%0d exp=1", pkt_count); end
    endtask

    task automatic test_gap();
        do_reset();
        src[3].push_back({1'b0, 8'hE0});
        src[3].push_back({1'b0, 8'hE1});
        src[3].push_back({1'b1, 8'hE2});
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        tick();
        tick();
        total++;
        if (grant !== 4'b1000 || fifo_write_en !== 1'b1) begin
            bad++;
            $display("FAIL gap_first: grant=%b we=%b exp 1000/1", grant, fifo_write_en);
        end
        hold_nxt = 4'b1000;
        src[0].push_back({1'b1, 8'h50});
        exp_q.push_back(8'h50);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (grant !== 4'b1000 || fifo_write_en !== 1'b0 || req_ready !== 4'b1000) begin
                bad++;
                $display("FAIL gap_hold_%0d: grant=%b we=%b ready=%b exp 1000/0/1000",
                         c, grant, fifo_write_en, req_ready);
            end
        end
        hold_nxt = 4'b0000;
        tick();
        tick();
        tick();
        total++;
        if (grant !== 4'b0000) begin bad++; $display("FAIL gap_idle: got=%b exp=0000", grant); end
        tick();
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL gap_req0: got=%b exp=0001", grant); end
        drain("gap");
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 4; b++) begin
            src[2].push_back({(b == 3), 8'(8'h60 + b)});
            exp_q.push_back(8'(8'h60 + b));
        end
        tick();
        tick();
        tick();
        total++;
        if (fifo_write_en !== 1'b1 || grant !== 4'b0100) begin
            bad++;
            $display("FAIL rmid_beat2: we=%b grant=%b exp 1/0100", fifo_write_en, grant);
        end
        reset = 1'b1;
        flush();
        drive();
        #1;
        total += 4;
        if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant: got=%b exp=0000", grant); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got=%b exp=0", busy); end
        if (pkt_count !== 16'd0) begin bad++; $display("FAIL rmid_pkt: got=%0d exp=0", pkt_count); end
        if (fifo_write_en !== 1'b0) begin bad++; $display("FAIL rmid_we: got=%b exp=0", fifo_write_en); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        src[0].push_back({1'b1, 8'h70});
        src[1].push_back({1'b1, 8'h71});
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h71);
        tick();
        tick();
        total++;
        if (grant !== 4'b0001) begin bad++; $display("FAIL rmid_rearb: got=%b exp=0001", grant); end
        drain("reset_mid");
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        flush();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
